// File: rtl/avmm_job_pkg.sv
// Shared definitions for the host-side Avalon-MM job sequencer:
// register map of the accelerator slave, control/status bit positions and FSM states.
package avmm_job_pkg;

    localparam logic [7:0] REG_CTRL     = 8'h00;
    localparam logic [7:0] REG_MODE     = 8'h01;
    localparam logic [7:0] REG_XRATIO   = 8'h02;
    localparam logic [7:0] REG_YRATIO   = 8'h03;
    localparam logic [7:0] REG_IMG_DATA = 8'h04;
    localparam logic [7:0] REG_IMG_ADDR = 8'h05;
    localparam logic [7:0] REG_STATUS   = 8'h06;
    localparam logic [7:0] REG_PERF     = 8'h07;

    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_STEP_BIT   = 1;
    localparam int STATUS_DONE_BIT = 0;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_W_MODE  = 4'd1,
        ST_W_XR    = 4'd2,
        ST_W_YR    = 4'd3,
        ST_P_ADDR  = 4'd4,
        ST_P_DATA  = 4'd5,
        ST_W_START = 4'd6,
        ST_W_CLR   = 4'd7,
        ST_POLL_RD = 4'd8,
        ST_POLL_WT = 4'd9,
        ST_PERF_RD = 4'd10,
        ST_PERF_WT = 4'd11,
        ST_FIN     = 4'd12
    } state_t;

endpackage

// File: rtl/avmm_read_waiter.sv
// Tracks a single outstanding Avalon read: counts RD_LAT cycles after the strobe
// and then pulses rd_valid for one cycle with the captured read data.
module avmm_read_waiter #(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_issue,
    input  logic [31:0] rd_data,
    output logic        rd_valid,
    output logic [31:0] rd_captured
);

    localparam int CW = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);

    logic [CW-1:0] cnt_r;
    logic          rd_valid_r;
    logic [31:0]   data_r;

    // Latency countdown; readdata is sampled on the last counted cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r      <= {CW{1'b0}};
            rd_valid_r <= 1'b0;
            data_r     <= 32'd0;
        end else begin
            rd_valid_r <= (cnt_r == CW'(1));
            if (cnt_r == CW'(1)) begin
                data_r <= rd_data;
            end
            if (rd_issue) begin
                cnt_r <= CW'(RD_LAT);
            end else if (cnt_r != {CW{1'b0}}) begin
                cnt_r <= cnt_r - CW'(1);
            end
        end
    end

    assign rd_valid    = rd_valid_r;
    assign rd_captured = data_r;

endmodule

// File: rtl/avmm_job_host.sv
// Avalon-MM master that configures the accelerator, streams an image into it,
// kicks it off, polls for completion and captures the performance counter.
module avmm_job_host
    import avmm_job_pkg::*;
#(
    parameter int          RD_LAT   = 1,
    parameter int          NPIX_W   = 18,
    parameter logic [31:0] POLL_MAX = 32'd50_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              job_start,
    input  logic              job_mode,
    input  logic [31:0]       job_xratio,
    input  logic [31:0]       job_yratio,
    input  logic [NPIX_W-1:0] job_npix,
    input  logic              pix_valid,
    input  logic [7:0]        pix_data,
    output logic              pix_ready,
    output logic              busy,
    output logic              job_done,
    output logic [31:0]       job_cycles,
    output logic              timeout_err,
    output logic              avm_read,
    output logic              avm_write,
    output logic [7:0]        avm_address,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata
);

    state_t            state_r, state_nxt;
    logic              mode_r;
    logic [31:0]       xr_r, yr_r;
    logic [NPIX_W-1:0] npix_r, idx_r;
    logic [31:0]       poll_cnt_r;

    logic              rd_s, wr_s;
    logic [7:0]        addr_s;
    logic [31:0]       wdata_s;
    logic              accept_s, timeout_s, perf_cap_s, last_pix_s;

    logic              avm_read_r, avm_write_r;
    logic [7:0]        addr_r;
    logic [31:0]       wdata_r;
    logic              pix_ready_r, busy_r, job_done_r, timeout_r;
    logic [31:0]       cycles_r;

    logic              rd_valid_s;
    logic [31:0]       rd_data_s;

    avmm_read_waiter #(.RD_LAT(RD_LAT)) u_waiter (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_issue    (avm_read_r),
        .rd_data     (avm_readdata),
        .rd_valid    (rd_valid_s),
        .rd_captured (rd_data_s)
    );

    assign last_pix_s = ({1'b0, idx_r} + {{NPIX_W{1'b0}}, 1'b1}) >= {1'b0, npix_r};

    // Next state and the bus action this state commits (presented on the next cycle).
    always_comb begin
        state_nxt  = state_r;
        rd_s       = 1'b0;
        wr_s       = 1'b0;
        addr_s     = 8'h00;
        wdata_s    = 32'd0;
        accept_s   = 1'b0;
        timeout_s  = 1'b0;
        perf_cap_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // busy_r still high here means the job just ended; that start is dropped
                if (job_start && !busy_r) begin
                    accept_s  = 1'b1;
                    state_nxt = ST_W_MODE;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_W_MODE: begin
                wr_s      = 1'b1;
                addr_s    = REG_MODE;
                wdata_s   = {31'd0, mode_r};
                state_nxt = ST_W_XR;
            end
            ST_W_XR: begin
                wr_s      = 1'b1;
                addr_s    = REG_XRATIO;
                wdata_s   = xr_r;
                state_nxt = ST_W_YR;
            end
            ST_W_YR: begin
                wr_s      = 1'b1;
                addr_s    = REG_YRATIO;
                wdata_s   = yr_r;
                state_nxt = (npix_r != {NPIX_W{1'b0}}) ? ST_P_ADDR : ST_W_START;
            end
            ST_P_ADDR: begin
                if (pix_valid) begin
                    wr_s      = 1'b1;
                    addr_s    = REG_IMG_ADDR;
                    wdata_s   = {{(32-NPIX_W){1'b0}}, idx_r};
                    state_nxt = ST_P_DATA;
                end else begin
                    state_nxt = ST_P_ADDR;
                end
            end
            ST_P_DATA: begin
                wr_s      = 1'b1;
                addr_s    = REG_IMG_DATA;
                wdata_s   = {24'd0, pix_data};
                state_nxt = last_pix_s ? ST_W_START : ST_P_ADDR;
            end
            ST_W_START: begin
                wr_s      = 1'b1;
                addr_s    = REG_CTRL;
                wdata_s   = 32'd1 << CTRL_START_BIT;
                state_nxt = ST_W_CLR;
            end
            ST_W_CLR: begin
                wr_s      = 1'b1;
                addr_s    = REG_CTRL;
                wdata_s   = 32'd0;
                state_nxt = ST_POLL_RD;
            end
            ST_POLL_RD: begin
                rd_s      = 1'b1;
                addr_s    = REG_STATUS;
                state_nxt = ST_POLL_WT;
            end
            ST_POLL_WT: begin
                if (rd_valid_s) begin
                    if (rd_data_s[STATUS_DONE_BIT]) begin
                        state_nxt = ST_PERF_RD;
                    end else if (poll_cnt_r == POLL_MAX) begin
                        timeout_s = 1'b1;
                        state_nxt = ST_FIN;
                    end else begin
                        state_nxt = ST_POLL_RD;
                    end
                end else begin
                    state_nxt = ST_POLL_WT;
                end
            end
            ST_PERF_RD: begin
                rd_s      = 1'b1;
                addr_s    = REG_PERF;
                state_nxt = ST_PERF_WT;
            end
            ST_PERF_WT: begin
                if (rd_valid_s) begin
                    perf_cap_s = 1'b1;
                    state_nxt  = ST_FIN;
                end else begin
                    state_nxt = ST_PERF_WT;
                end
            end
            ST_FIN: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register and registered bus/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            avm_read_r  <= 1'b0;
            avm_write_r <= 1'b0;
            addr_r      <= 8'h00;
            wdata_r     <= 32'd0;
            pix_ready_r <= 1'b0;
            busy_r      <= 1'b0;
            job_done_r  <= 1'b0;
        end else begin
            state_r     <= state_nxt;
            avm_read_r  <= rd_s;
            avm_write_r <= wr_s;
            addr_r      <= addr_s;
            wdata_r     <= wdata_s;
            pix_ready_r <= (state_nxt == ST_P_DATA);
            busy_r      <= (state_r != ST_IDLE);
            job_done_r  <= (state_r == ST_FIN);
        end
    end

    // Job parameters, pixel index, poll counter and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_r     <= 1'b0;
            xr_r       <= 32'd0;
            yr_r       <= 32'd0;
            npix_r     <= {NPIX_W{1'b0}};
            idx_r      <= {NPIX_W{1'b0}};
            poll_cnt_r <= 32'd0;
            timeout_r  <= 1'b0;
            cycles_r   <= 32'd0;
        end else begin
            if (accept_s) begin
                mode_r     <= job_mode;
                xr_r       <= job_xratio;
                yr_r       <= job_yratio;
                npix_r     <= job_npix;
                idx_r      <= {NPIX_W{1'b0}};
                poll_cnt_r <= 32'd0;
                timeout_r  <= 1'b0;
            end
            if (state_r == ST_P_DATA) begin
                idx_r <= idx_r + {{(NPIX_W-1){1'b0}}, 1'b1};
            end
            if (state_r == ST_POLL_RD) begin
                poll_cnt_r <= poll_cnt_r + 32'd1;
            end
            if (timeout_s) begin
                timeout_r <= 1'b1;
                cycles_r  <= 32'hFFFF_FFFF;
            end
            if (perf_cap_s) begin
                cycles_r <= rd_data_s;
            end
        end
    end

    assign avm_read      = avm_read_r;
    assign avm_write     = avm_write_r;
    assign avm_address   = addr_r;
    assign avm_writedata = wdata_r;
    assign pix_ready     = pix_ready_r;
    assign busy          = busy_r;
    assign job_done      = job_done_r;
    assign job_cycles    = cycles_r;
    assign timeout_err   = timeout_r;

endmodule

// File: tb/tb_avmm_job_host.sv
// Self-checking bench for avmm_job_host: a transaction-list model of each job
// is compared against the Avalon bus every cycle, backed by hand-computed checks.
module tb_avmm_job_host;

    localparam int          NPIX_W  = 18;
    localparam logic [31:0] POLL_TB = 32'd8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              job_start = 1'b0;
    logic              job_mode = 1'b0;
    logic [31:0]       job_xratio = 32'd0;
    logic [31:0]       job_yratio = 32'd0;
    logic [NPIX_W-1:0] job_npix = '0;
    logic              pix_valid = 1'b0;
    logic [7:0]        pix_data = 8'd0;
    logic              pix_ready, busy, job_done, timeout_err;
    logic [31:0]       job_cycles;
    logic              avm_read, avm_write;
    logic [7:0]        avm_address;
    logic [31:0]       avm_writedata;
    logic [31:0]       avm_readdata = 32'd0;

    always #5 clk = ~clk;

    avmm_job_host #(.RD_LAT(1), .NPIX_W(NPIX_W), .POLL_MAX(POLL_TB)) dut (
        .clk(clk), .rst_n(rst_n), .job_start(job_start), .job_mode(job_mode),
        .job_xratio(job_xratio), .job_yratio(job_yratio), .job_npix(job_npix),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
        .busy(busy), .job_done(job_done), .job_cycles(job_cycles),
        .timeout_err(timeout_err), .avm_read(avm_read), .avm_write(avm_write),
        .avm_address(avm_address), .avm_writedata(avm_writedata),
        .avm_readdata(avm_readdata)
    );

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] data;
    } txn_t;

    txn_t        exp_q[$];
    int          stamp_q[$];
    logic [31:0] wlog_q[$];
    logic [7:0]  pix_mem[8];
    int checks = 0, errors = 0;
    int ncyc = 0, done_cnt = 0, ready_cnt = 0, rd06_cnt = 0;
    int p = 0, stall_idx = -1, stall_left = 0;
    int done_after = 0, poll_base = 0, status_polls = 0;
    logic [31:0] perf_val = 32'd0;

    // Slave register bank: STATUS reports done from the done_after-th poll of a job.
    always @(posedge clk) begin
        if (avm_read && avm_address == 8'h06) begin
            status_polls <= status_polls + 1;
            avm_readdata <= (done_after != 0 && (status_polls + 1 - poll_base) >= done_after) ? 32'd1 : 32'd0;
        end else if (avm_read && avm_address == 8'h07) begin
            avm_readdata <= perf_val;
        end else begin
            avm_readdata <= 32'd0;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic push_wr(input logic [7:0] a, input logic [31:0] d);
        exp_q.push_back(txn_t'{rd: 1'b0, wr: 1'b1, addr: a, data: d});
    endtask

    task automatic push_rd(input logic [7:0] a);
        exp_q.push_back(txn_t'{rd: 1'b1, wr: 1'b0, addr: a, data: 32'd0});
    endtask

    // One clock: sample at the falling edge and compare any bus strobe to the model.
    task automatic step();
        txn_t e;
        @(negedge clk);
        ncyc++;
        if (rst_n) begin
            if (job_done) done_cnt++;
            if (pix_ready) ready_cnt++;
            if (avm_read && avm_address == 8'h06) rd06_cnt++;
            if (avm_read || avm_write) begin
                checks++;
                if (avm_read && avm_write) begin
                    errors++;
                    $display("FAIL bus_both rd=%b wr=%b addr=%h", avm_read, avm_write, avm_address);
                end else if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL bus_unexpected rd=%b addr=%h data=%h", avm_read, avm_address, avm_writedata);
                end else begin
                    e = exp_q.pop_front();
                    if (e.rd !== avm_read || e.addr !== avm_address || (e.wr && e.data !== avm_writedata)) begin
                        errors++;
                        $display("FAIL bus_txn got rd=%b addr=%h data=%h exp rd=%b addr=%h data=%h",
                                 avm_read, avm_address, avm_writedata, e.rd, e.addr, e.data);
                    end
                end
                stamp_q.push_back(ncyc);
                if (avm_write && avm_address == 8'h04) wlog_q.push_back(avm_writedata);
            end
        end
    endtask

    task automatic drive_pix(input int npix);
        if (p < npix) begin
            if (p == stall_idx && stall_left > 0) begin
                pix_valid = 1'b0;
                stall_left--;
            end else begin
                pix_valid = 1'b1;
                pix_data  = pix_mem[p];
            end
        end else begin
            pix_valid = 1'b0;
        end
    endtask

    task automatic run_job(input logic mode, input logic [31:0] xr, input logic [31:0] yr,
                           input int npix, input int st_idx, input int st_len,
                           input int dn_after, input logic [31:0] perf);
        bit          exp_to;
        int          npoll;
        bit          got_done;
        int          dc0, rc0;
        exp_to = (dn_after == 0) || (dn_after > int'(POLL_TB));
        npoll  = exp_to ? int'(POLL_TB) : dn_after;
        exp_q.delete(); stamp_q.delete(); wlog_q.delete();
        push_wr(8'h01, {31'd0, mode});
        push_wr(8'h02, xr);
        push_wr(8'h03, yr);
        for (int i = 0; i < npix; i++) begin
            push_wr(8'h05, i);
            push_wr(8'h04, {24'd0, pix_mem[i]});
        end
        push_wr(8'h00, 32'd1);
        push_wr(8'h00, 32'd0);
        for (int i = 0; i < npoll; i++) push_rd(8'h06);
        if (!exp_to) push_rd(8'h07);

        done_after = dn_after; perf_val = perf; poll_base = status_polls;
        p = 0; stall_idx = st_idx; stall_left = st_len;
        dc0 = done_cnt; rc0 = ready_cnt;
        job_mode = mode; job_xratio = xr; job_yratio = yr; job_npix = NPIX_W'(npix);
        job_start = 1'b1;
        drive_pix(npix);
        step();
        job_start = 1'b0;
        job_mode = ~mode; job_xratio = 32'hDEAD_BEEF; job_yratio = 32'h0BAD_F00D; job_npix = NPIX_W'(7);
        chk("timeout_cleared_on_start", {31'd0, timeout_err}, 32'd0);
        got_done = 1'b0;
        for (int k = 0; k < 3000 && !got_done; k++) begin
            if (pix_ready) p++;
            else drive_pix(npix);
            job_start = (k == 6);
            step();
            if (job_done) got_done = 1'b1;
        end
        job_start = 1'b0;
        pix_valid = 1'b0;
        chk("job_done_seen", {31'd0, got_done}, 32'd1);
        chk("busy_with_done", {31'd0, busy}, 32'd1);
        chk("job_cycles", job_cycles, exp_to ? 32'hFFFF_FFFF : perf);
        chk("timeout_err", {31'd0, timeout_err}, {31'd0, exp_to});
        chk("bus_txns_left", exp_q.size(), 32'd0);
        chk("pix_ready_pulses", ready_cnt - rc0, npix);
        // a start coincident with the done pulse must be dropped
        job_start = 1'b1;
        step();
        job_start = 1'b0;
        chk("busy_falls_with_done", {31'd0, busy}, 32'd0);
        chk("done_single_pulse", {31'd0, job_done}, 32'd0);
        step();
        chk("start_at_done_ignored", {31'd0, busy}, 32'd0);
        chk("done_pulse_count", done_cnt - dc0, 32'd1);
    endtask

    initial begin
        int r0;
        // reset state
        repeat (3) @(negedge clk);
        chk("rst_read", {31'd0, avm_read}, 32'd0);
        chk("rst_write", {31'd0, avm_write}, 32'd0);
        chk("rst_addr", {24'd0, avm_address}, 32'd0);
        chk("rst_wdata", avm_writedata, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_cycles", job_cycles, 32'd0);
        chk("rst_flags", {29'd0, job_done, timeout_err, pix_ready}, 32'd0);
        rst_n = 1'b1;
        step();

        // configuration only, done on the first poll
        run_job(1'b1, 32'h8000, 32'h8000, 0, -1, 0, 1, 32'd77);
        chk("cfg_model_len", stamp_q.size(), 32'd7);
        chk("cfg_back_to_back", stamp_q[5] - stamp_q[0], 32'd5);

        // three-pixel load with an unbroken stream
        pix_mem[0] = 8'hA5; pix_mem[1] = 8'h3C; pix_mem[2] = 8'hFF;
        run_job(1'b0, 32'h1, 32'h2, 3, -1, 0, 1, 32'd5);
        chk("load_6_cycles", stamp_q[8] - stamp_q[3], 32'd5);
        chk("pix0", wlog_q[0], 32'h0000_00A5);
        chk("pix1", wlog_q[1], 32'h0000_003C);
        chk("pix2", wlog_q[2], 32'h0000_00FF);

        // five-cycle stream stall before pixel 1
        pix_mem[0] = 8'h11; pix_mem[1] = 8'h22; pix_mem[2] = 8'h33;
        run_job(1'b1, 32'h10, 32'h20, 3, 1, 5, 2, 32'd9);
        chk("stall_gap", stamp_q[5] - stamp_q[4], 32'd6);
        chk("stall_pre", stamp_q[4] - stamp_q[3], 32'd1);
        chk("stall_post", stamp_q[6] - stamp_q[5], 32'd1);

        // done after four negative polls
        run_job(1'b0, 32'h4000, 32'hC000, 0, -1, 0, 5, 32'd1234);
        chk("perf_1234", job_cycles, 32'd1234);

        // never done -> poll timeout
        r0 = rd06_cnt;
        run_job(1'b1, 32'h3, 32'h4, 0, -1, 0, 0, 32'd55);
        chk("timeout_reads", rd06_cnt - r0, 32'd8);
        chk("timeout_flag", {31'd0, timeout_err}, 32'd1);
        chk("timeout_cycles", job_cycles, 32'hFFFF_FFFF);

        // next job clears the sticky flag
        run_job(1'b0, 32'h5, 32'h6, 0, -1, 0, 3, 32'd42);

        // reset in the middle of the pixel load
        pix_mem[0] = 8'h77; pix_mem[1] = 8'h88; pix_mem[2] = 8'h99;
        exp_q.delete(); stamp_q.delete(); wlog_q.delete();
        push_wr(8'h01, 32'd1); push_wr(8'h02, 32'h7); push_wr(8'h03, 32'h8); push_wr(8'h05, 32'd0);
        p = 0; stall_idx = -1; stall_left = 0;
        job_mode = 1'b1; job_xratio = 32'h7; job_yratio = 32'h8; job_npix = NPIX_W'(3);
        job_start = 1'b1;
        drive_pix(3);
        step();
        job_start = 1'b0;
        for (int k = 0; k < 50 && !pix_ready; k++) begin
            drive_pix(3);
            step();
        end
        chk("reached_p_data", {31'd0, pix_ready}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_bus", {30'd0, avm_read, avm_write}, 32'd0);
        chk("mid_rst_addr", {24'd0, avm_address}, 32'd0);
        chk("mid_rst_wdata", avm_writedata, 32'd0);
        chk("mid_rst_status", {29'd0, busy, job_done, pix_ready}, 32'd0);
        chk("mid_rst_cycles", {31'd0, timeout_err}, 32'd0);
        chk("mid_rst_perf", job_cycles, 32'd0);
        chk("pre_rst_txns", exp_q.size(), 32'd0);
        pix_valid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        pix_mem[0] = 8'h5A; pix_mem[1] = 8'h6B;
        run_job(1'b0, 32'h9, 32'hA, 2, -1, 0, 1, 32'd100);
        chk("restart_pix0", wlog_q[0], 32'h0000_005A);
        chk("restart_pix1", wlog_q[1], 32'h0000_006B);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
